// File: rtl/lbp_update_queue.sv
// Queue of resolved conditional-branch outcomes feeding the local branch predictor's update port.
// Consecutive updates to the same PC are merged, and updates that arrive while the queue is full are counted, then dropped.
module lbp_update_queue #(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned IDX_W = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_bp_i,
  input  logic                         debug_mode_i,
  input  logic                         res_valid_i,
  input  logic [VLEN-1:0]              res_pc_i,
  input  logic                         res_taken_i,
  input  logic [IDX_W-1:0]             res_index_i,
  input  logic                         hold_i,
  output logic [VLEN+IDX_W+1:0]        bht_update_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [7:0]                   drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [VLEN-1:0]  pc_mem    [DEPTH];
  logic             taken_mem [DEPTH];
  logic [IDX_W-1:0] idx_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       drop_cnt_q;

  logic [PTR_W-1:0] last_ptr;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             pop;
  logic             coalesce;
  logic             accept;
  logic             drop;

  // The newest entry always sits just behind the write pointer; coalescing never moves it.
  always_comb begin
    last_ptr = wr_ptr_q - PTR_W'(1);
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    push_req = res_valid_i && !debug_mode_i && !flush_bp_i;
    pop      = !empty && !hold_i && !debug_mode_i && !flush_bp_i;
    // An entry leaving this cycle cannot absorb the new outcome, so it takes a fresh slot instead.
    coalesce = push_req && !empty && (pc_mem[last_ptr] == res_pc_i) &&
               !(pop && (last_ptr == rd_ptr_q));
    accept   = push_req && !coalesce && (!full || pop);
    drop     = push_req && !coalesce && full && !pop;
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pc_mem[wr_ptr_q]    <= res_pc_i;
      taken_mem[wr_ptr_q] <= res_taken_i;
      idx_mem[wr_ptr_q]   <= res_index_i;
    end else if (coalesce) begin
      taken_mem[last_ptr] <= res_taken_i;
      idx_mem[last_ptr]   <= res_index_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (flush_bp_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (accept) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
      end
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bht_update_o = {pop, pc_mem[rd_ptr_q], taken_mem[rd_ptr_q], idx_mem[rd_ptr_q]};
  assign count_o      = count_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_lbp_update_queue.sv
// Self-checking bench for lbp_update_queue: a table of per-cycle vectors, followed by hand-written multi-cycle sequences.
// A scoreboard queue holds the expected updates; they are popped and compared whenever the queue issues.
module tb_lbp_update_queue;

  localparam int unsigned VLEN  = 64;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned DEPTH = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_bp_i;
  logic                  debug_mode_i;
  logic                  res_valid_i;
  logic [VLEN-1:0]       res_pc_i;
  logic                  res_taken_i;
  logic [IDX_W-1:0]      res_index_i;
  logic                  hold_i;
  logic [VLEN+IDX_W+1:0] bht_update_o;
  logic [2:0]            count_o;
  logic [7:0]            drop_cnt_o;

  lbp_update_queue #(.VLEN(VLEN), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_bp_i   (flush_bp_i),
    .debug_mode_i (debug_mode_i),
    .res_valid_i  (res_valid_i),
    .res_pc_i     (res_pc_i),
    .res_taken_i  (res_taken_i),
    .res_index_i  (res_index_i),
    .hold_i       (hold_i),
    .bht_update_o (bht_update_o),
    .count_o      (count_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [VLEN-1:0]  pc;
    logic             taken;
    logic [IDX_W-1:0] idx;
  } upd_t;

  // sb: 0 = nothing expected, 1 = new entry, 2 = merge into newest, 3 = discard all
  typedef struct {
    logic            rv;
    logic [63:0]     pc;
    logic            tk;
    logic [6:0]      idx;
    logic            hold;
    int              sb;
    logic            e_valid;
    int              e_count;
  } vec_t;

  upd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_drop = 0;

  wire              upd_valid = bht_update_o[VLEN+IDX_W+1];
  wire [VLEN-1:0]   upd_pc    = bht_update_o[VLEN+IDX_W:IDX_W+1];
  wire              upd_taken = bht_update_o[IDX_W];
  wire [IDX_W-1:0]  upd_idx   = bht_update_o[IDX_W-1:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Every issued update must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_pc=%0h expected=none @%0t", upd_pc, $time);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        chk("issue_pc", upd_pc, e.pc);
        chk("issue_taken", 64'(upd_taken), 64'(e.taken));
        chk("issue_index", 64'(upd_idx), 64'(e.idx));
      end
    end
  end

  task automatic apply(input logic rv, input logic [63:0] pc, input logic tk, input logic [6:0] idx,
                       input logic hold, input logic dbg, input logic flush, input int sb);
    upd_t e;
    res_valid_i  = rv;
    res_pc_i     = pc;
    res_taken_i  = tk;
    res_index_i  = idx;
    hold_i       = hold;
    debug_mode_i = dbg;
    flush_bp_i   = flush;
    if (sb == 1) begin
      e.pc = pc; e.taken = tk; e.idx = idx;
      exp_q.push_back(e);
    end else if (sb == 2) begin
      e = exp_q.pop_back();
      e.taken = tk; e.idx = idx;
      exp_q.push_back(e);
    end else if (sb == 3) begin
      exp_q.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic hold);
    apply(1'b0, 64'h0, 1'b0, 7'h0, hold, 1'b0, 1'b0, 0);
  endtask

  task automatic status(input string tag, input logic e_valid, input int e_count, input int e_drop);
    chk({tag, "_valid"}, 64'(upd_valid), 64'(e_valid));
    chk({tag, "_count"}, 64'(count_o), 64'(e_count));
    chk({tag, "_drop"}, 64'(drop_cnt_o), 64'(e_drop));
  endtask

  vec_t tbl[12];

  initial begin
    // Single push latency, push-during-issue, and a same-PC push racing the issue of the newest entry.
    tbl[0]  = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b0, 0};
    tbl[1]  = '{1'b1, 64'h80000010, 1'b1, 7'h15, 1'b0, 1, 1'b0, 0};
    tbl[2]  = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b1, 1};
    tbl[3]  = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b0, 0};
    tbl[4]  = '{1'b1, 64'h200,      1'b0, 7'h01, 1'b0, 1, 1'b0, 0};
    tbl[5]  = '{1'b1, 64'h204,      1'b1, 7'h02, 1'b0, 1, 1'b1, 1};
    tbl[6]  = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b1, 1};
    tbl[7]  = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b0, 0};
    tbl[8]  = '{1'b1, 64'h300,      1'b1, 7'h03, 1'b0, 1, 1'b0, 0};
    tbl[9]  = '{1'b1, 64'h300,      1'b0, 7'h04, 1'b0, 1, 1'b1, 1};
    tbl[10] = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b1, 1};
    tbl[11] = '{1'b0, 64'h0,        1'b0, 7'h00, 1'b0, 0, 1'b0, 0};

    rst_ni = 1'b0;
    flush_bp_i = 1'b0; debug_mode_i = 1'b0; res_valid_i = 1'b0;
    res_pc_i = '0; res_taken_i = 1'b0; res_index_i = '0; hold_i = 1'b0;
    @(negedge clk_i);
    status("reset", 1'b0, 0, 0);
    adv();
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].rv, tbl[i].pc, tbl[i].tk, tbl[i].idx, tbl[i].hold, 1'b0, 1'b0, tbl[i].sb);
      chk($sformatf("vec%0d_valid", i), 64'(upd_valid), 64'(tbl[i].e_valid));
      chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(tbl[i].e_count));
      adv();
    end

    // Five pushes under hold: the fifth overflows.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 64'h400 + 64'(i * 8), 1'(i), 7'(i + 16), 1'b1, 1'b0, 1'b0, (i < 4) ? 1 : 0);
      adv();
    end
    exp_drop = 1;
    idle(1'b1);
    status("overflow", 1'b0, 4, exp_drop);
    adv();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk($sformatf("drain%0d_valid", i), 64'(upd_valid), 64'h1);
      adv();
    end
    idle(1'b0);
    status("drained", 1'b0, 0, exp_drop);
    adv();

    // Same PC twice under hold merges into one entry.
    apply(1'b1, 64'h100, 1'b0, 7'h0A, 1'b1, 1'b0, 1'b0, 1);
    adv();
    apply(1'b1, 64'h100, 1'b1, 7'h0B, 1'b1, 1'b0, 1'b0, 2);
    adv();
    idle(1'b1);
    status("merge", 1'b0, 1, exp_drop);
    adv();
    idle(1'b0);
    status("merge_issue", 1'b1, 1, exp_drop);
    adv();
    idle(1'b0);
    status("merge_done", 1'b0, 0, exp_drop);
    adv();

    // Full queue with a simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 64'h500 + 64'(i * 4), 1'(i + 1), 7'(i + 32), 1'b1, 1'b0, 1'b0, 1);
      adv();
    end
    apply(1'b1, 64'h5F0, 1'b1, 7'h2F, 1'b0, 1'b0, 1'b0, 1);
    status("full_pushpop", 1'b1, 4, exp_drop);
    adv();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      status($sformatf("full_drain%0d", i), 1'b1, 4 - i, exp_drop);
      adv();
    end
    idle(1'b0);
    status("full_done", 1'b0, 0, exp_drop);
    adv();

    // Flush together with a push.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 64'h600 + 64'(i * 4), 1'b1, 7'(i), 1'b1, 1'b0, 1'b0, 1);
      adv();
    end
    apply(1'b1, 64'h6F0, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b1, 3);
    status("flush_cycle", 1'b0, 3, exp_drop);
    adv();
    idle(1'b0);
    status("flush_after", 1'b0, 0, exp_drop);
    adv();

    // Debug mode freezes the queue for ten cycles while pushes are offered.
    apply(1'b1, 64'h700, 1'b0, 7'h11, 1'b1, 1'b0, 1'b0, 1);
    adv();
    apply(1'b1, 64'h704, 1'b1, 7'h12, 1'b1, 1'b0, 1'b0, 1);
    adv();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 64'h780 + 64'(i * 4), 1'b1, 7'h33, 1'b0, 1'b1, 1'b0, 0);
      chk($sformatf("debug%0d_valid", i), 64'(upd_valid), 64'h0);
      chk($sformatf("debug%0d_count", i), 64'(count_o), 64'd2);
      adv();
    end
    idle(1'b0);
    status("debug_exit0", 1'b1, 2, exp_drop);
    adv();
    idle(1'b0);
    status("debug_exit1", 1'b1, 1, exp_drop);
    adv();
    idle(1'b0);
    status("debug_done", 1'b0, 0, exp_drop);
    adv();

    // Saturation of the drop counter.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 64'h800 + 64'(i * 4), 1'b0, 7'(i), 1'b1, 1'b0, 1'b0, 1);
      adv();
    end
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 64'h10000 + 64'(i * 4), 1'b1, 7'h44, 1'b1, 1'b0, 1'b0, 0);
      adv();
    end
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    idle(1'b1);
    status("saturate", 1'b0, 4, exp_drop);
    adv();
    apply(1'b0, 64'h0, 1'b0, 7'h0, 1'b0, 1'b0, 1'b1, 3);
    adv();
    idle(1'b0);
    status("sat_flushed", 1'b0, 0, exp_drop);
    adv();

    // Reset asserted while entries are queued and issue is enabled.
    apply(1'b1, 64'h900, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0, 1);
    adv();
    apply(1'b1, 64'h904, 1'b1, 7'h02, 1'b1, 1'b0, 1'b0, 1);
    adv();
    exp_q.delete();
    exp_drop = 0;
    hold_i = 1'b0;
    res_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    status("midreset", 1'b0, 0, exp_drop);
    @(negedge clk_i);
    status("midreset_hold", 1'b0, 0, exp_drop);
    adv();
    rst_ni = 1'b1;
    idle(1'b0);
    status("post_reset", 1'b0, 0, exp_drop);
    adv();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
